feature_mem_ctrl: RTL and testbench

Sequencer for the scratchpad feature memory. It accepts a stream of input-feature words over a valid/ready port and generates the write group/line addressing for the Tn×KERNEL_SIZE line store. It also generates the per-group read sweep that presents each convolution window. After the initial fill it runs in sliding mode: only one new line per group is written, into the oldest slot of a circular line ring. It sits between the DMA/input stream and the feature memory, and hands windows to the PE array through a valid/ack pair.

---
 rtl/feature_ctrl_pkg.sv | 26 ++
 rtl/feature_mem_ctrl_ring_ptr.sv | 42 ++++
 rtl/feature_mem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_feature_mem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_ctrl_pkg.sv
// Shared definitions for the feature-memory sequencer.
//   ADDR_W     : width of every group/line address (groups and lines are <=16)
//   WIN_CNT_W  : width of the window counter and cfg_num_windows
//   state_t    : controller state encoding
//   ring_inc() : modulo increment used by the circular line ring
package feature_ctrl_pkg;

  localparam int ADDR_W    = 4;
  localparam int WIN_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_READ     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_SLIDE    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Step a ring pointer, wrapping from `last` back to zero.
  function automatic logic [ADDR_W-1:0] ring_inc(input logic [ADDR_W-1:0] ptr,
                                                 input logic [ADDR_W-1:0] last);
    return (ptr == last) ? '0 : ptr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/feature_mem_ctrl_ring_ptr.sv
// ring_ptr: modulo-SIZE counter with synchronous clear and increment.
// Used for the fill line counter and for the ring head (oldest line).
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : force pointer to 0 (wins over inc_i)
//   inc_i    : advance pointer, wrapping SIZE-1 -> 0
//   ptr_o    : current pointer value
module ring_ptr
  import feature_ctrl_pkg::*;
#(
  parameter int SIZE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ring_inc(ptr_q, LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/feature_mem_ctrl.sv
// feature_mem_ctrl: sequencer for the Tn x KERNEL_SIZE scratchpad feature memory.
// Fills every line of every group, then alternates a Tn-cycle read sweep
// (presenting one convolution window) with a Tn-word slide that overwrites
// the oldest line of the circular ring.
//
// Handshakes: a word moves when in_valid & in_ready are both high at a rising
// clk edge; in_valid without in_ready is ignored. A window is offered while
// window_valid is high and is retired by window_ack in that state (ack in the
// first window_valid cycle counts); ack at any other time is ignored.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            begin a run (IDLE only), cfg_num_windows sampled with it
//   in_valid/ready   input word stream; in_data forwarded to mem_wdata
//   wr_en            combinational write strobe (= input handshake)
//   wr_mem_group/line registered write address
//   rd_en            read strobe during the sweep
//   rd_mem_group     group being read; rd_mem_line is the ring head
//   window_valid     window stable at memory outputs; window_ack retires it
//   busy, done       not-IDLE flag; one-cycle end-of-run pulse
//   dbg_state        current FSM state, for observation
module feature_mem_ctrl
  import feature_ctrl_pkg::*;
#(
  parameter int Tn             = 4,
  parameter int KERNEL_SIZE    = 3,
  parameter int DATA_BUS_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIN_CNT_W-1:0]      cfg_num_windows,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_BUS_WIDTH-1:0] in_data,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_mem_group,
  output logic [ADDR_W-1:0]         wr_mem_line,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_mem_group,
  output logic [ADDR_W-1:0]         rd_mem_line,
  output logic                      window_valid,
  input  logic                      window_ack,
  output logic                      busy,
  output logic                      done,
  output state_t                    dbg_state
);

  localparam logic [ADDR_W-1:0] GRP_LAST  = ADDR_W'(Tn - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(KERNEL_SIZE - 1);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      grp_q, grp_d;
  logic [ADDR_W-1:0]      rd_grp_q, rd_grp_d;
  logic [WIN_CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WIN_CNT_W-1:0]   cfg_q, cfg_d;
  logic                   line_clr, line_inc, head_clr, head_inc;
  logic [ADDR_W-1:0]      line_ptr, head_ptr;
  logic                   hs;

  // in_ready depends on state only, so the handshake has no path back
  // through the next-state logic.
  assign in_ready = (state_q == ST_FILL) || (state_q == ST_SLIDE);
  assign hs       = in_valid && in_ready;

  ring_ptr #(.SIZE(KERNEL_SIZE)) u_line_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (line_clr),
    .inc_i (line_inc),
    .ptr_o (line_ptr)
  );

  ring_ptr #(.SIZE(KERNEL_SIZE)) u_head_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (head_clr),
    .inc_i (head_inc),
    .ptr_o (head_ptr)
  );

  always_comb begin
    state_d      = state_q;
    grp_d        = grp_q;
    rd_grp_d     = rd_grp_q;
    win_cnt_d    = win_cnt_q;
    cfg_d        = cfg_q;
    line_clr     = 1'b0;
    line_inc     = 1'b0;
    head_clr     = 1'b0;
    head_inc     = 1'b0;
    rd_en        = 1'b0;
    window_valid = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_num_windows != '0) begin
            state_d   = ST_FILL;
            cfg_d     = cfg_num_windows;
            win_cnt_d = '0;
            grp_d     = '0;
            rd_grp_d  = '0;
            line_clr  = 1'b1;
            head_clr  = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FILL: begin
        // Group-major order: group steps every word, line steps on group wrap.
        if (hs) begin
          if (grp_q == GRP_LAST) begin
            grp_d    = '0;
            line_inc = 1'b1;
            if (line_ptr == LINE_LAST) begin
              state_d  = ST_READ;
              head_clr = 1'b1;
            end
          end else begin
            grp_d = grp_q + ADDR_W'(1);
          end
        end
      end
      ST_READ: begin
        rd_en = 1'b1;
        if (rd_grp_q == GRP_LAST) begin
          rd_grp_d = '0;
          state_d  = ST_WAIT_ACK;
        end else begin
          rd_grp_d = rd_grp_q + ADDR_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        window_valid = 1'b1;
        if (window_ack) begin
          win_cnt_d = win_cnt_q + WIN_CNT_W'(1);
          if (win_cnt_d == cfg_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SLIDE;
            grp_d   = '0;
          end
        end
      end
      ST_SLIDE: begin
        // One new line per group replaces the oldest slot (the head).
        if (hs) begin
          if (grp_q == GRP_LAST) begin
            grp_d    = '0;
            head_inc = 1'b1;
            state_d  = ST_READ;
          end else begin
            grp_d = grp_q + ADDR_W'(1);
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grp_q     <= '0;
      rd_grp_q  <= '0;
      win_cnt_q <= '0;
      cfg_q     <= '0;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      rd_grp_q  <= rd_grp_d;
      win_cnt_q <= win_cnt_d;
      cfg_q     <= cfg_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign wr_en        = hs;
  assign mem_wdata    = in_data;
  assign wr_mem_group = grp_q;
  assign wr_mem_line  = (state_q == ST_SLIDE) ? head_ptr : line_ptr;
  assign rd_mem_group = rd_grp_q;
  assign rd_mem_line  = head_ptr;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_feature_mem_ctrl.sv
module tb_feature_mem_ctrl;
  import feature_ctrl_pkg::*;

  localparam int TN = 4;
  localparam int KS = 3;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            start;
  logic [15:0]     cfg_num_windows;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [DW-1:0]   mem_wdata;
  logic            wr_en;
  logic [3:0]      wr_mem_group, wr_mem_line, rd_mem_group, rd_mem_line;
  logic            rd_en, window_valid, window_ack, busy, done;
  state_t          dbg_state;

  feature_mem_ctrl #(.Tn(TN), .KERNEL_SIZE(KS), .DATA_BUS_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_num_windows (cfg_num_windows),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .mem_wdata       (mem_wdata),
    .wr_en           (wr_en),
    .wr_mem_group    (wr_mem_group),
    .wr_mem_line     (wr_mem_line),
    .rd_en           (rd_en),
    .rd_mem_group    (rd_mem_group),
    .rd_mem_line     (rd_mem_line),
    .window_valid    (window_valid),
    .window_ack      (window_ack),
    .busy            (busy),
    .done            (done),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];     // {group, line, data} per expected write
  logic [7:0]  rd_exp_q[$];  // {group, line} per expected read
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int word_cnt = 0;
  int wr_cnt = 0;
  bit src_en = 1'b0;
  bit src_rnd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stream driver + output monitor ----------------
  // Drives in_valid/in_data 1 unit after each falling edge, then inspects
  // the write and read strobes 1 unit later, well before the rising edge.
  initial begin
    bit hs;
    logic [23:0] e;
    logic [7:0]  r;
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (src_en) in_valid = src_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      else        in_valid = 1'b0;
      in_data = word_cnt[DW-1:0];
      #1;
      hs = in_valid && in_ready;
      if (wr_en) begin
        wr_cnt++;
        check("wr_needs_valid", 32'(in_valid), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'({wr_mem_group, wr_mem_line, mem_wdata}), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("write_addr_data", 32'({wr_mem_group, wr_mem_line, mem_wdata}), 32'(e));
        end
      end
      if (rd_en) begin
        if (rd_exp_q.size() == 0) begin
          check("unexpected_read", 32'({rd_mem_group, rd_mem_line}), 32'hFFFFFFFF);
        end else begin
          r = rd_exp_q.pop_front();
          check("read_addr", 32'({rd_mem_group, rd_mem_line}), 32'(r));
        end
      end
      if (hs) begin
        word_cnt++;
        last_hs_cyc = cyc;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic build_model(input int cfg, input int base);
    if (cfg > 0) begin
      for (int k = 0; k < TN * KS; k++)
        exp_q.push_back({4'(k % TN), 4'(k / TN), 16'(base + k)});
      for (int w = 1; w < cfg; w++)
        for (int g = 0; g < TN; g++)
          exp_q.push_back({4'(g), 4'((w - 1) % KS), 16'(base + TN * KS + TN * (w - 1) + g)});
      for (int w = 1; w <= cfg; w++)
        for (int g = 0; g < TN; g++)
          rd_exp_q.push_back({4'(g), 4'((w - 1) % KS)});
    end
  endtask

  task automatic recover();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    rd_exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_window(output bit ok);
    int t;
    t = 0;
    while (!window_valid && t < 400) begin
      @(negedge clk);
      #1;
      t++;
    end
    ok = window_valid;
    check("window_arrives", 32'(window_valid), 32'd1);
  endtask

  task automatic run_case(input int cfg, input bit rnd, input int ack_delay,
                          input bit glitch, input int exp_writes);
    bit ok;
    bit stable;
    src_rnd = rnd;
    wr_cnt  = 0;
    build_model(cfg, word_cnt);
    @(negedge clk);
    start = 1'b1;
    cfg_num_windows = 16'(cfg);
    @(negedge clk);
    start = 1'b0;
    #1;
    if (cfg == 0) check("cfg0_done_next_cycle", 32'({done, busy}), 32'b11);
    else          check("busy_after_start", 32'(dbg_state), 32'(ST_FILL));
    if (glitch) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      cfg_num_windows = 16'd7;
      window_ack = 1'b1;
      @(negedge clk);
      start = 1'b0;
      window_ack = 1'b0;
      cfg_num_windows = 16'(cfg);
    end
    for (int w = 1; w <= cfg; w++) begin
      wait_window(ok);
      if (!ok) begin
        recover();
        return;
      end
      if (w == 1) check("first_window_latency", 32'(cyc - last_hs_cyc), 32'(TN + 1));
      check("window_line", 32'({in_ready, rd_mem_line}), 32'({1'b0, 4'((w - 1) % KS)}));
      stable = 1'b1;
      repeat (ack_delay) begin
        @(negedge clk);
        #1;
        if (!window_valid || in_ready || rd_mem_line != 4'((w - 1) % KS)) stable = 1'b0;
      end
      check("window_held_until_ack", 32'(stable), 32'd1);
      window_ack = 1'b1;
      @(negedge clk);
      window_ack = 1'b0;
      #1;
      check("ack_response", 32'({window_valid, done}), 32'({1'b0, (w == cfg)}));
    end
    @(negedge clk);
    #1;
    check("idle_after_run", 32'({busy, done}), 32'd0);
    check("write_count", 32'(wr_cnt), 32'(exp_writes));
    check("writes_all_seen", 32'(exp_q.size()), 32'd0);
    check("reads_all_seen", 32'(rd_exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int cfg;
    bit rnd;
    int ack_delay;
    bit glitch;
    int exp_writes;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int t;
    bit done_seen;
    tbl[0] = '{1, 1'b0, 0, 1'b0, 12};  // plain fill, single window
    tbl[1] = '{5, 1'b0, 0, 1'b0, 28};  // slide ring wrap-around
    tbl[2] = '{5, 1'b1, 7, 1'b0, 28};  // bubbles on input, slow consumer
    tbl[3] = '{0, 1'b1, 0, 1'b0, 0};   // empty run
    tbl[4] = '{3, 1'b1, 2, 1'b1, 20};  // start/ack pulses during fill

    rst = 1'b1;
    start = 1'b0;
    cfg_num_windows = '0;
    window_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("reset_idle_outputs",
            32'({in_ready, wr_en, rd_en, window_valid, busy, done,
                 wr_mem_group, wr_mem_line, rd_mem_group, rd_mem_line, dbg_state}), 32'd0);
    end
    src_en = 1'b1;

    for (int i = 0; i < 5; i++)
      run_case(tbl[i].cfg, tbl[i].rnd, tbl[i].ack_delay, tbl[i].glitch, tbl[i].exp_writes);

    // Reset in the middle of the first slide.
    src_rnd = 1'b0;
    wr_cnt = 0;
    build_model(3, word_cnt);
    @(negedge clk);
    start = 1'b1;
    cfg_num_windows = 16'd3;
    @(negedge clk);
    start = 1'b0;
    begin
      bit ok;
      wait_window(ok);
    end
    window_ack = 1'b1;
    @(negedge clk);
    window_ack = 1'b0;
    t = 0;
    while (wr_cnt < TN * KS + 2 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("mid_slide_reached", 32'(dbg_state), 32'(ST_SLIDE));
    @(negedge clk);
    rst = 1'b1;
    src_en = 1'b0;
    exp_q.delete();
    rd_exp_q.delete();
    @(negedge clk);
    #1;
    check("idle_after_reset", 32'({busy, done, dbg_state, rd_mem_line}), 32'd0);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (done) done_seen = 1'b1;
    end
    check("no_done_after_reset", 32'(done_seen), 32'd0);
    src_en = 1'b1;
    run_case(1, 1'b0, 0, 1'b0, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
